imem_boot_loader: RTL and testbench

Streams a program image from a byte source (UART RX) into the processor instruction memory, then releases the core from reset. It sits directly upstream of the instruction memory and the core reset input. It replaces simulation-only memory preloading with a synthesizable load path. The image is framed as sync byte, 16-bit word count, little-endian data words and an 8-bit checksum.

---
 rtl/imem_boot_pkg.sv | 30 +++
 rtl/boot_word_assembler.sv | 45 ++++
 rtl/imem_boot_loader.sv | 160 ++++++++++++++++
 tb/tb_imem_boot_loader.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/imem_boot_pkg.sv
// imem_boot_pkg: shared types and constants for the instruction-memory boot loader.
// Latency: n/a (types, constants and a state-decode helper only).
// Backpressure: n/a.
// Contents: loader FSM state enum, default frame sync byte, byte-index width,
//           and a helper that says which states take bytes from the source.
package imem_boot_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LEN_LO,
      LEN_HI,
      DATA,
      WRITE,
      CSUM,
      DONE,
      ERR
   } boot_state_t;

   localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

   // Four bytes per 32-bit word.
   localparam int BYTE_IDX_W = 2;

   // States in which the loader is willing to take a byte from the source.
   function automatic logic state_takes_bytes(input boot_state_t s);
      return (s == IDLE) || (s == LEN_LO) || (s == LEN_HI) ||
             (s == DATA) || (s == CSUM);
   endfunction

endpackage

// File: rtl/boot_word_assembler.sv
// boot_word_assembler: packs accepted data bytes little-endian into 32-bit words and sums them mod 256.
// Latency: word/csum update on the edge that accepts a byte; word_complete is combinational with the 4th accept.
// Backpressure: none of its own; the parent only pulses accept when a byte is really taken.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   data_byte       byte to absorb when accept is high
//   accept          absorb data_byte this cycle
//   clear           restart a frame: byte index and checksum go to zero
//   word            assembled word (first byte in [7:0], fourth in [31:24])
//   word_complete   high in the cycle the 4th byte of a word is accepted
//   csum            running mod-256 sum of all accepted bytes since clear
module boot_word_assembler
   import imem_boot_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  data_byte,
   input  logic        accept,
   input  logic        clear,
   output logic [31:0] word,
   output logic        word_complete,
   output logic [7:0]  csum
);

   logic [BYTE_IDX_W-1:0] byte_idx;

   always_ff @(posedge clk) begin
      if (rst) begin
         word     <= '0;
         byte_idx <= '0;
         csum     <= '0;
      end else if (clear) begin
         byte_idx <= '0;
         csum     <= '0;
      end else if (accept) begin
         // Shifting in from the top leaves byte 0 in [7:0] after four bytes.
         word     <= {data_byte, word[31:8]};
         byte_idx <= byte_idx + 1'b1;
         csum     <= csum + data_byte;
      end
   end

   assign word_complete = accept && (byte_idx == '1);

endmodule

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: streams a framed image (sync, 16-bit LE length, LE words, 8-bit sum) into imem, then releases the core.
// Latency: imem_we in the cycle after a word's 4th byte; boot_done/core_rstn the cycle after a good checksum byte.
// Backpressure: rx_ready drops during WRITE, DONE and ERR; a byte offered then is held by the source, not lost.
// Optional feature macro: BOOT_TIMEOUT_EN (inter-byte timeout of TIMEOUT_CYCLES outside IDLE).
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   rx_data/rx_valid/rx_ready byte source handshake (accept when valid && ready)
//   imem_we/imem_addr/imem_wdata  instruction memory write port
//   core_rstn                active-low core reset, released only on a good load
//   boot_done / boot_err     sticky load-complete / load-failed flags
//   words_loaded             number of words written in the current frame
module imem_boot_loader
   import imem_boot_pkg::*;
#(
   parameter int         MEM_DEPTH      = 64,
   parameter int         ADDR_W         = $clog2(MEM_DEPTH),
   parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT,
   parameter int         TIMEOUT_CYCLES = 100000
)(
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              core_rstn,
   output logic              boot_done,
   output logic              boot_err,
   output logic [ADDR_W:0]   words_loaded
);

   if (MEM_DEPTH < 1 || MEM_DEPTH > 65535) begin : g_bad_depth
      $error("imem_boot_loader: MEM_DEPTH must be 1..65535");
   end
   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("imem_boot_loader: TIMEOUT_CYCLES must be at least 2");
   end

   boot_state_t       state, state_nxt;
   logic [15:0]       len;
   logic [15:0]       len_full;
   logic [ADDR_W:0]   word_idx;
   logic [ADDR_W:0]   word_idx_inc;
   logic              accept;
   logic              sync_seen;
   logic              asm_accept;
   logic [31:0]       asm_word;
   logic              asm_word_complete;
   logic [7:0]        asm_csum;
   logic              tmo_expired;

   assign accept       = rx_valid && rx_ready;
   assign sync_seen    = accept && (state == IDLE) && (rx_data == SYNC_BYTE);
   assign asm_accept   = accept && (state == DATA);
   assign len_full     = {rx_data, len[7:0]};
   assign word_idx_inc = word_idx + 1'b1;

   boot_word_assembler u_asm (
      .clk           (clk),
      .rst           (rst),
      .data_byte     (rx_data),
      .accept        (asm_accept),
      .clear         (sync_seen),
      .word          (asm_word),
      .word_complete (asm_word_complete),
      .csum          (asm_csum)
   );

`ifdef BOOT_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES);

   logic [TMO_W-1:0] tmo_cnt;
   logic             tmo_state;

   // IDLE is deliberately excluded: the loader may wait forever for a frame.
   assign tmo_state   = (state == LEN_LO) || (state == LEN_HI) ||
                        (state == DATA)   || (state == CSUM);
   assign tmo_expired = tmo_state && !accept &&
                        (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         tmo_cnt <= '0;
      end else if (accept || (state_nxt != state) || !tmo_state) begin
         tmo_cnt <= '0;
      end else begin
         tmo_cnt <= tmo_cnt + 1'b1;
      end
   end
`else
   assign tmo_expired = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (sync_seen) state_nxt = LEN_LO;
         end
         LEN_LO: begin
            if (accept) state_nxt = LEN_HI;
         end
         LEN_HI: begin
            // Length is validated before any write, so imem_addr stays in range.
            if (accept) begin
               if (len_full > 16'(MEM_DEPTH)) state_nxt = ERR;
               else if (len_full == 16'd0)    state_nxt = CSUM;
               else                           state_nxt = DATA;
            end
         end
         DATA: begin
            if (asm_word_complete) state_nxt = WRITE;
         end
         WRITE: begin
            if (16'(word_idx_inc) == len) state_nxt = CSUM;
            else                          state_nxt = DATA;
         end
         CSUM: begin
            if (accept) state_nxt = (rx_data == asm_csum) ? DONE : ERR;
         end
         DONE:    state_nxt = DONE;
         ERR:     state_nxt = ERR;
         default: state_nxt = IDLE;
      endcase
      if (tmo_expired) state_nxt = ERR;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         len       <= '0;
         word_idx  <= '0;
         rx_ready  <= 1'b0;
         imem_we   <= 1'b0;
         core_rstn <= 1'b0;
         boot_done <= 1'b0;
         boot_err  <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept && (state == LEN_LO)) len[7:0]  <= rx_data;
         if (accept && (state == LEN_HI)) len[15:8] <= rx_data;
         if (sync_seen)                   word_idx  <= '0;
         else if (state == WRITE)         word_idx  <= word_idx_inc;
         // Status outputs are registered from the next state so they line up
         // with the state they describe without a decode after the flops.
         rx_ready  <= state_takes_bytes(state_nxt);
         imem_we   <= (state_nxt == WRITE);
         core_rstn <= (state_nxt == DONE);
         boot_done <= (state_nxt == DONE);
         boot_err  <= (state_nxt == ERR);
      end
   end

   assign imem_addr    = word_idx[ADDR_W-1:0];
   assign imem_wdata   = asm_word;
   assign words_loaded = word_idx;

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: directed-vector bench for imem_boot_loader.
// Latency: checks write strobe one cycle after a word's last byte and status right after the checksum byte.
// Backpressure: byte driver waits (bounded) on rx_ready before each byte.
module tb_imem_boot_loader;

   localparam int MEM_DEPTH = 64;
   localparam int ADDR_W    = 6;

   logic              clk = 1'b0;
   logic              rst;
   logic [7:0]        rx_data;
   logic              rx_valid;
   logic              rx_ready;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic              core_rstn;
   logic              boot_done;
   logic              boot_err;
   logic [ADDR_W:0]   words_loaded;

   int vectors     = 0;
   int miscompares = 0;
   int wr_cnt      = 0;
   int dbl_we      = 0;
   logic we_prev   = 1'b0;

   always #5 clk = ~clk;

   imem_boot_loader #(
      .MEM_DEPTH      (MEM_DEPTH),
      .ADDR_W         (ADDR_W),
      .SYNC_BYTE      (8'hA5),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .rx_ready     (rx_ready),
      .imem_we      (imem_we),
      .imem_addr    (imem_addr),
      .imem_wdata   (imem_wdata),
      .core_rstn    (core_rstn),
      .boot_done    (boot_done),
      .boot_err     (boot_err),
      .words_loaded (words_loaded)
   );

   // Write monitor: counts strobe cycles and flags any strobe longer than one cycle.
   always @(negedge clk) begin
      if (imem_we) begin
         wr_cnt++;
         if (we_prev) dbl_we++;
      end
      we_prev = imem_we;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      @(negedge clk);
      rx_data  = b;
      rx_valid = 1'b1;
      while (!rx_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!rx_ready) check("rdy_wait", 32'(rx_ready), 32'd1);
      @(posedge clk);
      #1 rx_valid = 1'b0;
   endtask

   // Sends one word LE and checks the strobe that must follow immediately.
   task automatic send_word(input string tag, input logic [31:0] w, input int addr);
      for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
      check({tag, "_we"},    32'(imem_we),   32'd1);
      check({tag, "_addr"},  32'(imem_addr), 32'(addr));
      check({tag, "_wdata"}, imem_wdata,     w);
   endtask

   // Data-byte sum: 13+10+93+20 = D6 (zero bytes add nothing).
   task automatic send_nominal(input string tag, input logic [7:0] cs);
      send_byte(8'hA5);
      send_byte(8'h02);
      send_byte(8'h00);
      send_word({tag, "_w0"}, 32'h0010_0013, 0);
      send_word({tag, "_w1"}, 32'h0020_0093, 1);
      send_byte(cs);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_rdy"},   32'(rx_ready),     32'd0);
      check({tag, "_we"},    32'(imem_we),      32'd0);
      check({tag, "_addr"},  32'(imem_addr),    32'd0);
      check({tag, "_wdata"}, imem_wdata,        32'd0);
      check({tag, "_rstn"},  32'(core_rstn),    32'd0);
      check({tag, "_done"},  32'(boot_done),    32'd0);
      check({tag, "_err"},   32'(boot_err),     32'd0);
      check({tag, "_words"}, 32'(words_loaded), 32'd0);
   endtask

   initial begin
      int base;
      int first_err;

      // Reset state
      rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
      repeat (2) @(posedge clk);
      #1 check_reset_vals("rst");
      rst = 1'b0;

      // Nominal load
      base = wr_cnt;
      send_nominal("nom", 8'hD6);
      check("nom_done",   32'(boot_done),    32'd1);
      check("nom_rstn",   32'(core_rstn),    32'd1);
      check("nom_err",    32'(boot_err),     32'd0);
      check("nom_words",  32'(words_loaded), 32'd2);
      check("nom_rdy",    32'(rx_ready),     32'd0);
      check("nom_wrcnt",  32'(wr_cnt - base), 32'd2);
      check("nom_we_len", 32'(dbl_we),       32'd0);
      // Bytes offered while not ready are ignored; DONE stays sticky.
      @(negedge clk);
      rx_data = 8'hA5; rx_valid = 1'b1;
      repeat (5) @(negedge clk);
      rx_valid = 1'b0;
      check("ign_done",  32'(boot_done),     32'd1);
      check("ign_words", 32'(words_loaded),  32'd2);
      check("ign_wrcnt", 32'(wr_cnt - base), 32'd2);

      // Bad checksum
      do_reset();
      base = wr_cnt;
      send_nominal("bad", 8'hD7);
      check("bad_err",   32'(boot_err),      32'd1);
      check("bad_done",  32'(boot_done),     32'd0);
      check("bad_rstn",  32'(core_rstn),     32'd0);
      check("bad_rdy",   32'(rx_ready),      32'd0);
      check("bad_words", 32'(words_loaded),  32'd2);
      check("bad_wrcnt", 32'(wr_cnt - base), 32'd2);
      repeat (3) @(negedge clk);
      check("bad_sticky", 32'(boot_err),     32'd1);

      // Oversize length (0x41 = 65 > 64)
      do_reset();
      base = wr_cnt;
      send_byte(8'hA5);
      send_byte(8'h41);
      send_byte(8'h00);
      check("big_err",  32'(boot_err), 32'd1);
      check("big_rstn", 32'(core_rstn), 32'd0);
      repeat (10) @(negedge clk);
      check("big_wrcnt", 32'(wr_cnt - base), 32'd0);
      check("big_rdy",   32'(rx_ready),      32'd0);

      // Zero length after junk
      do_reset();
      base = wr_cnt;
      send_byte(8'h00);
      send_byte(8'hFF);
      send_byte(8'hA5);
      send_byte(8'h00);
      send_byte(8'h00);
      send_byte(8'h00);
      check("zero_done",  32'(boot_done),     32'd1);
      check("zero_rstn",  32'(core_rstn),     32'd1);
      check("zero_words", 32'(words_loaded),  32'd0);
      check("zero_wrcnt", 32'(wr_cnt - base), 32'd0);

      // Mid-load reset, then a clean frame
      do_reset();
      send_byte(8'hA5);
      send_byte(8'h02);
      send_byte(8'h00);
      send_byte(8'h13);
      send_byte(8'h00);
      @(negedge clk) rst = 1'b1;
      @(negedge clk) rst = 1'b0;
      check_reset_vals("mid");
      base = wr_cnt;
      send_nominal("rel", 8'hD6);
      check("rel_done",  32'(boot_done),     32'd1);
      check("rel_words", 32'(words_loaded),  32'd2);
      check("rel_wrcnt", 32'(wr_cnt - base), 32'd2);

      // Silence after the low length byte
      do_reset();
      send_byte(8'hA5);
      send_byte(8'h01);
`ifdef BOOT_TIMEOUT_EN
      first_err = 0;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk);
         #1;
         if (boot_err && first_err == 0) first_err = i;
      end
      check("tmo_cycles", 32'(first_err), 32'd16);
      check("tmo_rstn",   32'(core_rstn), 32'd0);
`else
      first_err = 0;
      for (int i = 1; i <= 1000; i++) begin
         @(posedge clk);
         #1;
         if (boot_err && first_err == 0) first_err = i;
      end
      check("notmo_err", 32'(first_err), 32'd0);
      check("notmo_rdy", 32'(rx_ready),  32'd1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
